// File: rtl/vend_pkg.sv
// Shared types and constants for the vending sequencer: states, coin values, price defaults.
package vend_pkg;

    localparam int unsigned CREDIT_W       = 7;
    localparam int unsigned COIN_LO        = 5;
    localparam int unsigned COIN_HI        = 10;
    localparam int unsigned PRICE_A_DEF    = 40;
    localparam int unsigned PRICE_B_DEF    = 45;
    localparam int unsigned CREDIT_MAX_DEF = 95;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } state_t;

    // Credit value of a coin; hi selects the 10-unit coin.
    function automatic logic [CREDIT_W-1:0] coin_value(input logic hi);
        return hi ? CREDIT_W'(COIN_HI) : CREDIT_W'(COIN_LO);
    endfunction

endpackage

// File: rtl/vend_idle_timer.sv
// Idle timer: counts enabled cycles and flags expiry when the count reaches TIMEOUT_CYC-1.
module vend_idle_timer #(
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign expired = enable && (count_q == CNT_W'(TIMEOUT_CYC - 1));

    // Saturate at the expiry value so a stalled consumer never sees a wrap.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vend_sequencer.sv
// Vending sequencer: collects coins, vends on selection, pays change or refunds via handshakes.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int unsigned PRICE_A     = PRICE_A_DEF,
    parameter int unsigned PRICE_B     = PRICE_B_DEF,
    parameter int unsigned CREDIT_MAX  = CREDIT_MAX_DEF,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       coin_valid,
    input  logic       coin_type,
    output logic       coin_rej,
    input  logic       sel_valid,
    input  logic       sel_item,
    output logic       sel_nack,
    input  logic       cancel,
    output logic       vend_req,
    input  logic       vend_ack,
    output logic       chg_req,
    input  logic       chg_ack,
    output logic       chg_type,
    output logic [6:0] credit,
    output logic       busy
);

    state_t                state_q, state_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic                  coin_rej_q, coin_rej_d;
    logic                  sel_nack_q, sel_nack_d;
    logic                  vend_req_q, vend_req_d;
    logic                  chg_req_q, chg_req_d;
    logic                  chg_type_q, chg_type_d;
    logic                  busy_q, busy_d;
    logic [CREDIT_W-1:0]   coin_sum;
    logic [CREDIT_W-1:0]   price;
    logic                  coin_acc;
    logic                  chg_taken;
    logic                  timer_clr;
    logic                  timer_exp;

    vend_idle_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_idle_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (timer_clr),
        .enable (state_q == ST_CREDIT),
        .expired(timer_exp)
    );

    assign coin_sum = credit_q + coin_value(coin_type);
    assign price    = sel_item ? CREDIT_W'(PRICE_B) : CREDIT_W'(PRICE_A);

    // Next state, credit and registered-output values.
    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        coin_rej_d = 1'b0;
        sel_nack_d = 1'b0;
        coin_acc   = 1'b0;
        chg_taken  = 1'b0;

        case (state_q)
            ST_IDLE, ST_CREDIT: begin
                if (cancel && (state_q == ST_CREDIT)) begin
                    state_d    = ST_CHANGE;
                    coin_rej_d = coin_valid;
                end else if (sel_valid) begin
                    coin_rej_d = coin_valid;
                    if ((state_q == ST_CREDIT) && (credit_q >= price)) begin
                        credit_d = credit_q - price;
                        state_d  = ST_VEND;
                    end else begin
                        sel_nack_d = 1'b1;
                    end
                end else if (coin_valid) begin
                    if (coin_sum <= CREDIT_W'(CREDIT_MAX)) begin
                        credit_d = coin_sum;
                        state_d  = ST_CREDIT;
                        coin_acc = 1'b1;
                    end else begin
                        coin_rej_d = 1'b1;
                    end
                end else if (timer_exp) begin
                    state_d = ST_CHANGE;
                end
            end
            ST_VEND: begin
                coin_rej_d = coin_valid;
                if (vend_req_q && vend_ack) begin
                    state_d = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
                end
            end
            ST_CHANGE: begin
                coin_rej_d = coin_valid;
                if (credit_q == '0) begin
                    state_d = ST_IDLE;
                end else if (chg_req_q && chg_ack) begin
                    chg_taken = 1'b1;
                    credit_d  = credit_q - coin_value(credit_q >= CREDIT_W'(COIN_HI));
                    if (credit_d == '0) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // chg_req drops for one cycle after each accepted payout.
        vend_req_d = (state_d == ST_VEND);
        chg_req_d  = (state_d == ST_CHANGE) && !chg_taken;
        chg_type_d = (state_d == ST_CHANGE) && (credit_d >= CREDIT_W'(COIN_HI));
        busy_d     = (state_d == ST_VEND) || (state_d == ST_CHANGE);
        timer_clr  = (state_d != state_q) || coin_acc;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            credit_q   <= '0;
            coin_rej_q <= 1'b0;
            sel_nack_q <= 1'b0;
            vend_req_q <= 1'b0;
            chg_req_q  <= 1'b0;
            chg_type_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            coin_rej_q <= coin_rej_d;
            sel_nack_q <= sel_nack_d;
            vend_req_q <= vend_req_d;
            chg_req_q  <= chg_req_d;
            chg_type_q <= chg_type_d;
            busy_q     <= busy_d;
        end
    end

    assign coin_rej = coin_rej_q;
    assign sel_nack = sel_nack_q;
    assign vend_req = vend_req_q;
    assign chg_req  = chg_req_q;
    assign chg_type = chg_type_q;
    assign credit   = credit_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed self-checking bench for vend_sequencer with hand-computed expectations.
module tb_vend_sequencer;

    localparam int unsigned TIMEOUT = 1000;

    logic       clk;
    logic       reset_n;
    logic       coin_valid;
    logic       coin_type;
    logic       coin_rej;
    logic       sel_valid;
    logic       sel_item;
    logic       sel_nack;
    logic       cancel;
    logic       vend_req;
    logic       vend_ack;
    logic       chg_req;
    logic       chg_ack;
    logic       chg_type;
    logic [6:0] credit;
    logic       busy;

    int total = 0;
    int bad   = 0;

    vend_sequencer #(
        .PRICE_A    (40),
        .PRICE_B    (45),
        .CREDIT_MAX (95),
        .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .coin_valid(coin_valid),
        .coin_type (coin_type),
        .coin_rej  (coin_rej),
        .sel_valid (sel_valid),
        .sel_item  (sel_item),
        .sel_nack  (sel_nack),
        .cancel    (cancel),
        .vend_req  (vend_req),
        .vend_ack  (vend_ack),
        .chg_req   (chg_req),
        .chg_ack   (chg_ack),
        .chg_type  (chg_type),
        .credit    (credit),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic ty);
        coin_valid = 1'b1;
        coin_type  = ty;
        step();
        coin_valid = 1'b0;
    endtask

    // Wait (bounded) for chg_req, check coin type, ack it, check gap and re-assert.
    task automatic pay_coin(input string tag, input logic ty, input int cr_after);
        int n = 0;
        while (!chg_req && n < 20) begin
            step();
            n++;
        end
        check({tag, "_req"}, 8'(chg_req), 8'd1);
        check({tag, "_typ"}, 8'(chg_type), 8'(ty));
        chg_ack = 1'b1;
        step();
        chg_ack = 1'b0;
        check({tag, "_gap"}, 8'(chg_req), 8'd0);
        check({tag, "_cr"}, 8'(credit), 8'(cr_after));
        check({tag, "_busy"}, 8'(busy), 8'(cr_after != 0));
        if (cr_after != 0) begin
            step();
            check({tag, "_rearm"}, 8'(chg_req), 8'd1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        coin_valid = 1'b0;
        coin_type  = 1'b0;
        sel_valid  = 1'b0;
        sel_item   = 1'b0;
        cancel     = 1'b0;
        vend_ack   = 1'b0;
        chg_ack    = 1'b0;
        step();
        step();
        check("rst_credit", 8'(credit), 8'd0);
        check("rst_outs", {2'b0, coin_rej, sel_nack, vend_req, chg_req, chg_type, busy}, 8'd0);
        reset_n = 1'b1;

        // Exact price with 10-unit coins, plus coin refused during VEND.
        repeat (4) coin(1'b1);
        check("a_credit40", 8'(credit), 8'd40);
        sel_valid = 1'b1; sel_item = 1'b0;
        step();
        sel_valid = 1'b0;
        check("a_credit0", 8'(credit), 8'd0);
        check("a_vreq", 8'(vend_req), 8'd1);
        check("a_busy", 8'(busy), 8'd1);
        coin(1'b1);
        check("a_vend_rej", 8'(coin_rej), 8'd1);
        check("a_vreq_hold", 8'(vend_req), 8'd1);
        check("a_vend_cr", 8'(credit), 8'd0);
        vend_ack = 1'b1;
        step();
        vend_ack = 1'b0;
        check("a_vreq_done", 8'(vend_req), 8'd0);
        check("a_rej_clr", 8'(coin_rej), 8'd0);
        check("a_nochg", 8'(chg_req), 8'd0);
        check("a_idle", 8'(busy), 8'd0);

        // Item B from 50: one 5-unit change coin.
        repeat (5) coin(1'b1);
        check("b_credit50", 8'(credit), 8'd50);
        sel_valid = 1'b1; sel_item = 1'b1;
        step();
        sel_valid = 1'b0;
        check("b_credit5", 8'(credit), 8'd5);
        check("b_vreq", 8'(vend_req), 8'd1);
        vend_ack = 1'b1;
        step();
        vend_ack = 1'b0;
        check("b_vreq_done", 8'(vend_req), 8'd0);
        pay_coin("b_c5", 1'b0, 0);
        step();
        check("b_one_chg", 8'(chg_req), 8'd0);

        // Credit ceiling.
        repeat (9) coin(1'b1);
        check("c_credit90", 8'(credit), 8'd90);
        coin(1'b1);
        check("c_rej", 8'(coin_rej), 8'd1);
        check("c_cr90", 8'(credit), 8'd90);
        step();
        check("c_rej_pulse", 8'(coin_rej), 8'd0);
        coin(1'b0);
        check("c_cr95", 8'(credit), 8'd95);
        check("c_norej", 8'(coin_rej), 8'd0);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        for (int i = 0; i < 9; i++) pay_coin("c_c10", 1'b1, 85 - 10 * i);
        pay_coin("c_c5", 1'b0, 0);

        // Insufficient credit then cancel refund of 35.
        repeat (3) coin(1'b1);
        coin(1'b0);
        check("d_cr35", 8'(credit), 8'd35);
        sel_valid = 1'b1; sel_item = 1'b0;
        step();
        sel_valid = 1'b0;
        check("d_nack", 8'(sel_nack), 8'd1);
        check("d_cr_keep", 8'(credit), 8'd35);
        check("d_novend", 8'(vend_req), 8'd0);
        step();
        check("d_nack_pulse", 8'(sel_nack), 8'd0);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        check("d_busy", 8'(busy), 8'd1);
        pay_coin("d_c10a", 1'b1, 25);
        pay_coin("d_c10b", 1'b1, 15);
        pay_coin("d_c10c", 1'b1, 5);
        pay_coin("d_c5", 1'b0, 0);

        // Idle timeout refund of 15.
        coin(1'b1);
        coin(1'b0);
        check("e_cr15", 8'(credit), 8'd15);
        repeat (TIMEOUT - 1) step();
        check("e_not_yet", 8'(busy), 8'd0);
        step();
        check("e_timeout", 8'(busy), 8'd1);
        check("e_req", 8'(chg_req), 8'd1);
        pay_coin("e_c10", 1'b1, 5);
        pay_coin("e_c5", 1'b0, 0);

        // Cancel beats a same-cycle coin.
        coin(1'b1);
        cancel = 1'b1; coin_valid = 1'b1; coin_type = 1'b1;
        step();
        cancel = 1'b0; coin_valid = 1'b0;
        check("f_rej", 8'(coin_rej), 8'd1);
        check("f_cr10", 8'(credit), 8'd10);
        check("f_req", 8'(chg_req), 8'd1);
        step();
        check("f_rej_pulse", 8'(coin_rej), 8'd0);
        pay_coin("f_c10", 1'b1, 0);

        // Reset in the middle of CHANGE.
        coin(1'b1);
        coin(1'b1);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        check("g_req", 8'(chg_req), 8'd1);
        check("g_cr20", 8'(credit), 8'd20);
        #2;
        reset_n = 1'b0;
        #1;
        check("g_rst_cr", 8'(credit), 8'd0);
        check("g_rst_outs", {2'b0, coin_rej, sel_nack, vend_req, chg_req, chg_type, busy}, 8'd0);
        step();
        reset_n    = 1'b1;
        coin_valid = 1'b1;
        coin_type  = 1'b0;
        step();
        coin_valid = 1'b0;
        check("g_first_coin", 8'(credit), 8'd5);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        pay_coin("g_c5", 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
